// File: rtl/enigma_core.sv
// Enigma I cipher core: rotors I-V, reflector B, rings at A, no plugboard.
// Each letter steps the rotors, then walks R,M,L, reflector, L,M,R one stage per cycle.
module enigma_core (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic        ready_out,
  input  logic        rotor_valid_in,
  input  logic [8:0]  rotor_select_in,
  input  logic [14:0] rotor_initial_in,
  input  logic        letter_valid_in,
  input  logic [4:0]  char_in,
  output logic        char_valid_out,
  output logic [4:0]  char_out,
  output logic [14:0] rotor_pos_out
);

  localparam int unsigned LW = 5;
  localparam int unsigned NL = 26;
  localparam logic [2:0]  REFL_B = 3'd5;
  localparam logic [8:0]  ORDER_RST = 9'b000_001_010;

  localparam logic [207:0] W_I    = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  localparam logic [207:0] W_II   = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
  localparam logic [207:0] W_III  = "BDFHJLCPRTXVZNYEIWGAKMOUSQ";
  localparam logic [207:0] W_IV   = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
  localparam logic [207:0] W_V    = "VZBRGITYUPSDNHLXAWMJQOFECK";
  localparam logic [207:0] W_UKWB = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

  typedef enum logic [3:0] {
    S_IDLE, S_STEP, S_F0, S_F1, S_F2, S_REFL, S_B0, S_B1, S_B2, S_OUT
  } state_t;

  // Letter 'idx' of wiring table 'rot' (index 5 selects the reflector).
  function automatic logic [LW-1:0] table_lut(input logic [2:0] rot, input logic [LW-1:0] idx);
    logic [207:0] tbl;
    logic [7:0]   sh;
    case (rot)
      3'd1:    tbl = W_II;
      3'd2:    tbl = W_III;
      3'd3:    tbl = W_IV;
      3'd4:    tbl = W_V;
      3'd5:    tbl = W_UKWB;
      default: tbl = W_I;
    endcase
    sh = {5'd25 - idx, 3'b000};
    return LW'(tbl[sh +: 8] - 8'd65);
  endfunction

  function automatic logic [LW-1:0] inv_lut(input logic [2:0] rot, input logic [LW-1:0] c);
    logic [LW-1:0] r;
    r = '0;
    for (int k = 0; k < NL; k++) begin
      if (table_lut(rot, LW'(k)) == c) r = LW'(k);
    end
    return r;
  endfunction

  function automatic logic [LW-1:0] add26(input logic [LW-1:0] a, input logic [LW-1:0] b);
    logic [LW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 6'd26) s = s - 6'd26;
    return s[LW-1:0];
  endfunction

  function automatic logic [LW-1:0] sub26(input logic [LW-1:0] a, input logic [LW-1:0] b);
    logic [LW:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (a < b) s = s + 6'd26;
    return s[LW-1:0];
  endfunction

  function automatic logic [LW-1:0] notch(input logic [2:0] rot);
    case (rot)
      3'd0:    return 5'd16;
      3'd1:    return 5'd4;
      3'd2:    return 5'd21;
      3'd3:    return 5'd9;
      default: return 5'd25;
    endcase
  endfunction

  function automatic logic [2:0] fix_sel(input logic [2:0] f);
    return (f > 3'd4) ? 3'd0 : f;
  endfunction

  function automatic logic [LW-1:0] fix_pos(input logic [LW-1:0] p);
    return (p >= 5'd26) ? p - 5'd26 : p;
  endfunction

  state_t        state_q, state_d;
  logic [8:0]    order_q, order_d;
  logic [14:0]   pos_q, pos_d;
  logic [LW-1:0] data_q, data_d;
  logic          bypass_q, bypass_d;
  logic          ready_q, ready_d;
  logic          valid_q, valid_d;
  logic [LW-1:0] out_q, out_d;

  logic [2:0]    rot_r, rot_m, rot_l, stage_rot;
  logic [LW-1:0] pos_r, pos_m, pos_l, stage_pos, stage_in;
  logic [LW-1:0] fwd_c, inv_c, refl_c;
  logic          step_m, step_l;

  assign rot_r = order_q[2:0];
  assign rot_m = order_q[5:3];
  assign rot_l = order_q[8:6];
  assign pos_r = pos_q[4:0];
  assign pos_m = pos_q[9:5];
  assign pos_l = pos_q[14:10];

  // Double-step: the middle rotor also advances when sitting on its own notch.
  assign step_m = (pos_r == notch(rot_r)) || (pos_m == notch(rot_m));
  assign step_l = (pos_m == notch(rot_m));

  // Rotor used by the current pipeline stage.
  always_comb begin
    stage_rot = rot_r;
    stage_pos = pos_r;
    case (state_q)
      S_F1, S_B1: begin stage_rot = rot_m; stage_pos = pos_m; end
      S_F2, S_B0: begin stage_rot = rot_l; stage_pos = pos_l; end
      default:    ;
    endcase
    stage_in = add26(data_q, stage_pos);
    fwd_c    = sub26(table_lut(stage_rot, stage_in), stage_pos);
    inv_c    = sub26(inv_lut(stage_rot, stage_in), stage_pos);
    refl_c   = table_lut(REFL_B, data_q);
  end

  always_comb begin
    state_d  = state_q;
    order_d  = order_q;
    pos_d    = pos_q;
    data_d   = data_q;
    bypass_d = bypass_q;
    ready_d  = ready_q;
    valid_d  = 1'b0;
    out_d    = out_q;
    case (state_q)
      S_IDLE: begin
        if (rotor_valid_in) begin
          order_d = {fix_sel(rotor_select_in[8:6]), fix_sel(rotor_select_in[5:3]),
                     fix_sel(rotor_select_in[2:0])};
          pos_d   = {fix_pos(rotor_initial_in[14:10]), fix_pos(rotor_initial_in[9:5]),
                     fix_pos(rotor_initial_in[4:0])};
        end else if (letter_valid_in) begin
          data_d   = char_in;
          bypass_d = (char_in >= 5'd26);
          ready_d  = 1'b0;
          state_d  = S_STEP;
        end
      end
      S_STEP: begin
        if (!bypass_q) begin
          pos_d[4:0] = add26(pos_r, 5'd1);
          if (step_m) pos_d[9:5]   = add26(pos_m, 5'd1);
          if (step_l) pos_d[14:10] = add26(pos_l, 5'd1);
        end
        state_d = S_F0;
      end
      S_F0:   begin if (!bypass_q) data_d = fwd_c;  state_d = S_F1;   end
      S_F1:   begin if (!bypass_q) data_d = fwd_c;  state_d = S_F2;   end
      S_F2:   begin if (!bypass_q) data_d = fwd_c;  state_d = S_REFL; end
      S_REFL: begin if (!bypass_q) data_d = refl_c; state_d = S_B0;   end
      S_B0:   begin if (!bypass_q) data_d = inv_c;  state_d = S_B1;   end
      S_B1:   begin if (!bypass_q) data_d = inv_c;  state_d = S_B2;   end
      S_B2:   begin if (!bypass_q) data_d = inv_c;  state_d = S_OUT;  end
      S_OUT: begin
        out_d   = data_q;
        valid_d = 1'b1;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= S_IDLE;
      order_q  <= ORDER_RST;
      pos_q    <= '0;
      data_q   <= '0;
      bypass_q <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      order_q  <= order_d;
      pos_q    <= pos_d;
      data_q   <= data_d;
      bypass_q <= bypass_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
    end
  end

  assign ready_out      = ready_q;
  assign char_valid_out = valid_q;
  assign char_out       = out_q;
  assign rotor_pos_out  = pos_q;

endmodule

// File: tb/tb_enigma_core.sv
// Directed bench for enigma_core: known Enigma I vectors, stepping, command arbitration, reset abort.
module tb_enigma_core;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        ready_out;
  logic        rotor_valid_in;
  logic [8:0]  rotor_select_in;
  logic [14:0] rotor_initial_in;
  logic        letter_valid_in;
  logic [4:0]  char_in;
  logic        char_valid_out;
  logic [4:0]  char_out;
  logic [14:0] rotor_pos_out;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  logic [4:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  enigma_core dut (
    .clk_in(clk_in), .rst_in(rst_in), .ready_out(ready_out),
    .rotor_valid_in(rotor_valid_in), .rotor_select_in(rotor_select_in),
    .rotor_initial_in(rotor_initial_in), .letter_valid_in(letter_valid_in),
    .char_in(char_in), .char_valid_out(char_valid_out), .char_out(char_out),
    .rotor_pos_out(rotor_pos_out)
  );

  always @(negedge clk_in) if (char_valid_out === 1'b1) pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [8:0] sel, input logic [14:0] ini);
    @(negedge clk_in);
    rotor_valid_in = 1'b1; rotor_select_in = sel; rotor_initial_in = ini;
    @(negedge clk_in);
    rotor_valid_in = 1'b0;
  endtask

  // Send one letter, optionally inject a stray letter pulse 'inject' edges after acceptance.
  task automatic send(input logic [4:0] c, input logic chk, input logic [4:0] expc, input int inject);
    int n;
    logic seen;
    logic [4:0] e;
    @(negedge clk_in);
    letter_valid_in = 1'b1; char_in = c;
    if (chk) exp_q.push_back(expc);
    @(negedge clk_in);
    letter_valid_in = 1'b0;
    n = 1; seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk_in);
      n++;
      letter_valid_in = (n == inject);
      if (char_valid_out === 1'b1) seen = 1'b1;
    end
    letter_valid_in = 1'b0;
    check("latency", seen ? n : 0, 10);
    if (chk) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'd0;
      check("char", seen ? 32'(char_out) : 32'hffff, 32'(e));
    end
  endtask

  initial begin
    logic [4:0] ct[5];
    int base;
    ct = '{5'd1, 5'd3, 5'd25, 5'd6, 5'd14};
    rst_in = 1'b0; rotor_valid_in = 1'b0; rotor_select_in = '0; rotor_initial_in = '0;
    letter_valid_in = 1'b0; char_in = '0;
    repeat (3) @(negedge clk_in);
    check("rst_ready", ready_out, 1);
    check("rst_valid", char_valid_out, 0);
    check("rst_char", char_out, 0);
    check("rst_pos", rotor_pos_out, 0);
    rst_in = 1'b1;

    // AAAAA at AAA with reset order I-II-III
    for (int i = 0; i < 5; i++) send(5'd0, 1'b1, ct[i], 0);
    check("pos_aaf", rotor_pos_out, 5);

    // Double-step from ADU
    load(9'b000_001_010, {5'd0, 5'd3, 5'd20});
    check("pos_adu", rotor_pos_out, 116);
    send(5'd0, 1'b0, 5'd0, 0); check("pos_adv", rotor_pos_out, 117);
    send(5'd0, 1'b0, 5'd0, 0); check("pos_aew", rotor_pos_out, 150);
    send(5'd0, 1'b0, 5'd0, 0); check("pos_bfx", rotor_pos_out, 1207);

    // Reciprocity
    load(9'b000_001_010, 15'd0);
    for (int i = 0; i < 5; i++) begin
      send(ct[i], 1'b1, 5'd0, 0);
      check("no_self", (char_out != ct[i]), 1);
    end

    // Out-of-range position fields wrap by 26
    load(9'b111_110_101, {5'd31, 5'd26, 5'd27});
    check("pos_fix", rotor_pos_out, {5'd5, 5'd0, 5'd1});

    // Simultaneous valids: config wins, letter dropped
    base = pulses;
    @(negedge clk_in);
    rotor_valid_in = 1'b1; letter_valid_in = 1'b1; char_in = 5'd7;
    rotor_select_in = 9'b000_001_010; rotor_initial_in = 15'd0;
    @(negedge clk_in);
    rotor_valid_in = 1'b0; letter_valid_in = 1'b0;
    repeat (14) @(negedge clk_in);
    check("both_nopulse", pulses - base, 0);
    check("both_pos", rotor_pos_out, 0);
    check("both_ready", ready_out, 1);

    // Stray letter while busy is ignored
    base = pulses;
    send(5'd0, 1'b1, 5'd1, 3);
    repeat (14) @(negedge clk_in);
    check("busy_onepulse", pulses - base, 1);
    check("busy_pos", rotor_pos_out, 1);

    // Out-of-range letter passes through unstepped
    send(5'd26, 1'b1, 5'd26, 0);
    check("bypass_pos", rotor_pos_out, 1);

    // Reset mid-letter, with a non-default order loaded first
    load(9'b100_011_010, 15'd0);
    base = pulses;
    @(negedge clk_in);
    letter_valid_in = 1'b1; char_in = 5'd0;
    @(negedge clk_in);
    letter_valid_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("abort_ready", ready_out, 1);
    check("abort_valid", char_valid_out, 0);
    check("abort_char", char_out, 0);
    check("abort_pos", rotor_pos_out, 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (15) @(negedge clk_in);
    check("abort_nopulse", pulses - base, 0);
    check("abort_ready2", ready_out, 1);
    send(5'd0, 1'b1, 5'd1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
